// File: rtl/detector_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : detector_cfg_pkg
//  Description : Register map, FSM state type and response codes shared by
//                the detector configuration controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package detector_cfg_pkg;

    // Word index of each register (byte address bits [3:2])
    localparam logic [1:0] REG_MAT  = 2'd0;
    localparam logic [1:0] REG_SR   = 2'd1;
    localparam logic [1:0] REG_SRS  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic [0:0] {
        CFG = 1'b0,
        RUN = 1'b1
    } cfg_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] reg_index(input logic [3:0] byte_addr);
        return byte_addr[3:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/detector_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : detector_cfg_ctrl_if
//  Description : AXI4-Lite bus bundle (4-bit address) with master and slave
//                views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface detector_cfg_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [3:0]            s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/axil_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axil_slave_if
//  Description : AXI4-Lite handshake engine; presents single-cycle write and
//                read requests to the register logic and returns responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_slave_if
    import detector_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    detector_cfg_ctrl_if.slave         s_axil,
    output logic                       wr_req,
    output logic [1:0]                 wr_addr,
    output logic [DATA_WIDTH-1:0]      wr_data,
    input  wire logic                  wr_err,
    output logic                       b_done,
    output logic [1:0]                 rd_addr,
    input  wire logic [DATA_WIDTH-1:0] rd_data
);

    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  unused_addr_lsbs;

    // Address and data are accepted together, and only with no response pending
    assign wr_hs   = s_axil.s_awvalid && s_axil.s_wvalid && !bvalid_q;
    assign rd_hs   = s_axil.s_arvalid && !rvalid_q;

    assign wr_req  = wr_hs;
    assign wr_addr = reg_index(s_axil.s_awaddr);
    assign wr_data = s_axil.s_wdata;
    assign b_done  = bvalid_q && s_axil.s_bready;
    assign rd_addr = reg_index(s_axil.s_araddr);

    assign unused_addr_lsbs = ^{s_axil.s_awaddr[1:0], s_axil.s_araddr[1:0]};

    assign s_axil.s_awready = wr_hs;
    assign s_axil.s_wready  = wr_hs;
    assign s_axil.s_bvalid  = bvalid_q;
    assign s_axil.s_bresp   = bresp_q;
    assign s_axil.s_arready = !rvalid_q;
    assign s_axil.s_rvalid  = rvalid_q;
    assign s_axil.s_rdata   = rdata_q;
    assign s_axil.s_rresp   = RESP_OKAY;

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (b_done) begin
            bvalid_d = 1'b0;
        end
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
        end else if (rvalid_q && s_axil.s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/detector_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : detector_cfg_ctrl
//  Description : Sequences matrix / sR / sRs loading into the hyperspectral
//                detector datapath and gates pixel streaming until complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_cfg_ctrl
    import detector_cfg_pkg::*;
#(
    parameter int NUM_BANDS       = 16,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int MAT_AW          = 8,
    parameter int SR_AW           = 4
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    detector_cfg_ctrl_if.slave              s_axil,
    input  wire logic                       dp_busy,
    output logic                            mat_we,
    output logic [MAT_AW-1:0]               mat_addr,
    output logic [BRAM_DATA_WIDTH-1:0]      mat_wdata,
    output logic                            sr_we,
    output logic [SR_AW-1:0]                sr_addr,
    output logic [BRAM_DATA_WIDTH-1:0]      sr_wdata,
    output logic [BRAM_DATA_WIDTH-1:0]      srs,
    output logic                            debug,
    output logic                            stream_en
);

    localparam logic [0:0]    S_CFG    = 1'(CFG);
    localparam logic [0:0]    S_RUN    = 1'(RUN);
    localparam logic [MAT_AW:0] MAT_FULL = (MAT_AW+1)'(NUM_BANDS * NUM_BANDS);
    localparam logic [SR_AW:0]  SR_FULL  = (SR_AW+1)'(NUM_BANDS);

    logic [0:0]                 state_q, state_d;
    logic [MAT_AW:0]            mat_cnt_q, mat_cnt_d;
    logic [SR_AW:0]             sr_cnt_q, sr_cnt_d;
    logic                       mat_we_q, mat_we_d;
    logic [MAT_AW-1:0]          mat_addr_q, mat_addr_d;
    logic [BRAM_DATA_WIDTH-1:0] mat_wdata_q, mat_wdata_d;
    logic                       sr_we_q, sr_we_d;
    logic [SR_AW-1:0]           sr_addr_q, sr_addr_d;
    logic [BRAM_DATA_WIDTH-1:0] sr_wdata_q, sr_wdata_d;
    logic [BRAM_DATA_WIDTH-1:0] srs_q, srs_d;
    logic                       debug_q, debug_d;
    logic                       stream_en_q, stream_en_d;
    logic                       run_pend_q, run_pend_d;

    logic                       wr_req;
    logic [1:0]                 wr_addr;
    logic [BRAM_DATA_WIDTH-1:0] wr_data;
    logic                       wr_err;
    logic                       b_done;
    logic [1:0]                 rd_addr;
    logic [BRAM_DATA_WIDTH-1:0] rd_data;
    logic                       leave_run;
    logic                       in_run;
    logic [MAT_AW:0]            mat_base;
    logic [SR_AW:0]             sr_base;

    axil_slave_if #(
        .DATA_WIDTH (BRAM_DATA_WIDTH)
    ) u_axil (
        .clk     (clk),
        .resetn  (resetn),
        .s_axil  (s_axil),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .b_done  (b_done),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign in_run = (state_q == S_RUN);
    // A data write in RUN restarts loading, so it lands at index 0
    assign mat_base = in_run ? '0 : mat_cnt_q;
    assign sr_base  = in_run ? '0 : sr_cnt_q;

    always_comb begin
        state_d     = state_q;
        mat_cnt_d   = mat_cnt_q;
        sr_cnt_d    = sr_cnt_q;
        mat_we_d    = 1'b0;
        mat_addr_d  = mat_addr_q;
        mat_wdata_d = mat_wdata_q;
        sr_we_d     = 1'b0;
        sr_addr_d   = sr_addr_q;
        sr_wdata_d  = sr_wdata_q;
        srs_d       = srs_q;
        debug_d     = debug_q;
        stream_en_d = stream_en_q;
        run_pend_d  = run_pend_q;
        wr_err      = 1'b0;
        leave_run   = 1'b0;

        // Streaming opens only once the master has seen the completing response
        if (b_done && run_pend_q) begin
            stream_en_d = 1'b1;
            run_pend_d  = 1'b0;
        end

        if (wr_req) begin
            case (wr_addr)
                REG_MAT, REG_SR: begin
                    if (in_run && dp_busy) begin
                        wr_err = 1'b1;
                    end else if (wr_addr == REG_MAT && mat_base == MAT_FULL) begin
                        wr_err = 1'b1;
                    end else if (wr_addr == REG_SR && sr_base == SR_FULL) begin
                        wr_err = 1'b1;
                    end else begin
                        if (in_run) begin
                            leave_run = 1'b1;
                            state_d   = S_CFG;
                        end
                        mat_cnt_d = mat_base;
                        sr_cnt_d  = sr_base;
                        if (wr_addr == REG_MAT) begin
                            mat_we_d    = 1'b1;
                            mat_addr_d  = mat_base[MAT_AW-1:0];
                            mat_wdata_d = wr_data;
                            mat_cnt_d   = mat_base + 1'b1;
                        end else begin
                            sr_we_d    = 1'b1;
                            sr_addr_d  = sr_base[SR_AW-1:0];
                            sr_wdata_d = wr_data;
                            sr_cnt_d   = sr_base + 1'b1;
                        end
                    end
                end
                REG_SRS: begin
                    srs_d = wr_data;
                    if (!in_run && mat_cnt_q == MAT_FULL && sr_cnt_q == SR_FULL) begin
                        state_d    = S_RUN;
                        run_pend_d = 1'b1;
                    end
                end
                default: begin
                    debug_d = wr_data[0];
                    if (wr_data[1]) begin
                        leave_run = 1'b1;
                        state_d   = S_CFG;
                        mat_cnt_d = '0;
                        sr_cnt_d  = '0;
                    end
                end
            endcase
        end

        if (leave_run) begin
            stream_en_d = 1'b0;
            run_pend_d  = 1'b0;
        end
    end

    // Reads see register state before any write accepted in the same cycle
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_MAT: rd_data = BRAM_DATA_WIDTH'(mat_cnt_q);
            REG_SR:  rd_data = BRAM_DATA_WIDTH'(sr_cnt_q);
            REG_SRS: rd_data = srs_q;
            default: rd_data = BRAM_DATA_WIDTH'({in_run, 1'b0, debug_q});
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_CFG;
            mat_cnt_q   <= '0;
            sr_cnt_q    <= '0;
            mat_we_q    <= 1'b0;
            mat_addr_q  <= '0;
            mat_wdata_q <= '0;
            sr_we_q     <= 1'b0;
            sr_addr_q   <= '0;
            sr_wdata_q  <= '0;
            srs_q       <= '0;
            debug_q     <= 1'b0;
            stream_en_q <= 1'b0;
            run_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mat_cnt_q   <= mat_cnt_d;
            sr_cnt_q    <= sr_cnt_d;
            mat_we_q    <= mat_we_d;
            mat_addr_q  <= mat_addr_d;
            mat_wdata_q <= mat_wdata_d;
            sr_we_q     <= sr_we_d;
            sr_addr_q   <= sr_addr_d;
            sr_wdata_q  <= sr_wdata_d;
            srs_q       <= srs_d;
            debug_q     <= debug_d;
            stream_en_q <= stream_en_d;
            run_pend_q  <= run_pend_d;
        end
    end

    assign mat_we    = mat_we_q;
    assign mat_addr  = mat_addr_q;
    assign mat_wdata = mat_wdata_q;
    assign sr_we     = sr_we_q;
    assign sr_addr   = sr_addr_q;
    assign sr_wdata  = sr_wdata_q;
    assign srs       = srs_q;
    assign debug     = debug_q;
    // Drops combinationally so no pixel is accepted on the cycle loading restarts
    assign stream_en = stream_en_q && !leave_run;

endmodule
`default_nettype wire

// File: tb/tb_detector_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_detector_cfg_ctrl
//  Description : Directed self-checking bench for detector_cfg_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_detector_cfg_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        dp_busy = 1'b0;
    logic        mat_we, sr_we, debug, stream_en;
    logic [7:0]  mat_addr;
    logic [3:0]  sr_addr;
    logic [31:0] mat_wdata, sr_wdata, srs;

    int checks = 0;
    int passes = 0;

    // Strobe monitors: expected index/data sequences maintained by the bench
    int mat_pulses = 0, mat_bad = 0, mon_mat_exp = 0;
    int sr_pulses  = 0, sr_bad  = 0, mon_sr_exp  = 0;

    detector_cfg_ctrl_if bus ();

    detector_cfg_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_axil    (bus.slave),
        .dp_busy   (dp_busy),
        .mat_we    (mat_we),
        .mat_addr  (mat_addr),
        .mat_wdata (mat_wdata),
        .sr_we     (sr_we),
        .sr_addr   (sr_addr),
        .sr_wdata  (sr_wdata),
        .srs       (srs),
        .debug     (debug),
        .stream_en (stream_en)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mat_we) begin
            if (mat_addr !== 8'(mon_mat_exp) || mat_wdata !== 32'(mon_mat_exp)) mat_bad++;
            mat_pulses++;
            mon_mat_exp++;
        end
        if (sr_we) begin
            if (sr_addr !== 4'(mon_sr_exp) || sr_wdata !== (32'hA000_0000 + 32'(mon_sr_exp))) sr_bad++;
            sr_pulses++;
            mon_sr_exp++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.s_awaddr = a; bus.s_wdata = d; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        #1;
        for (n = 0; n < 50 && !bus.s_awready; n++) begin @(negedge clk); #1; end
        if (n == 50) chk("aw_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        for (n = 0; n < 50 && !bus.s_bvalid; n++) begin @(posedge clk); #1; end
        if (n == 50) chk("b_timeout", 32'd0, 32'd1);
        resp = bus.s_bresp;
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        bus.s_araddr = a; bus.s_arvalid = 1'b1;
        #1;
        for (n = 0; n < 50 && !bus.s_arready; n++) begin @(negedge clk); #1; end
        if (n == 50) chk("ar_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
        for (n = 0; n < 50 && !bus.s_rvalid; n++) begin @(posedge clk); #1; end
        if (n == 50) chk("r_timeout", 32'd0, 32'd1);
        d = bus.s_rdata;
        bus.s_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          ok_cnt;

        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_mat_we", 32'(mat_we), 32'd0);
        chk("rst_stream_en", 32'(stream_en), 32'd0);
        chk("rst_srs", srs, 32'd0);
        chk("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Full matrix load
        ok_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            axi_write(4'h0, 32'(i), resp);
            if (resp == 2'b00) ok_cnt++;
        end
        @(negedge clk);
        chk("mat_okay_count", 32'(ok_cnt), 32'd256);
        chk("mat_pulses", 32'(mat_pulses), 32'd256);
        chk("mat_seq_bad", 32'(mat_bad), 32'd0);
        axi_read(4'h0, rd);
        chk("rd_mat_cnt", rd, 32'd256);

        // Matrix overflow
        axi_write(4'h0, 32'd999, resp);
        chk("ovf_bresp", 32'(resp), 32'h2);
        repeat (2) @(negedge clk);
        chk("ovf_no_we", 32'(mat_pulses), 32'd256);
        axi_read(4'h0, rd);
        chk("ovf_mat_cnt", rd, 32'd256);

        // Early sRs with only 10 sR words
        for (int i = 0; i < 10; i++) axi_write(4'h4, 32'hA000_0000 + 32'(i), resp);
        axi_write(4'h8, 32'h0000_1234, resp);
        chk("early_srs_bresp", 32'(resp), 32'h0);
        chk("early_stream_en", 32'(stream_en), 32'd0);
        axi_read(4'h8, rd);
        chk("early_srs_val", rd, 32'h0000_1234);
        axi_read(4'hC, rd);
        chk("early_ctrl", rd, 32'h0);

        // Complete sR, then the sRs write that arms streaming
        for (int i = 10; i < 16; i++) axi_write(4'h4, 32'hA000_0000 + 32'(i), resp);
        axi_write(4'h8, 32'h5D62_0008, resp);
        chk("run_bresp", 32'(resp), 32'h0);
        chk("run_srs", srs, 32'h5D62_0008);
        chk("run_stream_en", 32'(stream_en), 32'd1);
        axi_read(4'hC, rd);
        chk("run_ctrl", rd, 32'h4);
        chk("sr_pulses", 32'(sr_pulses), 32'd16);
        chk("sr_seq_bad", 32'(sr_bad), 32'd0);

        // sR write in RUN while busy is rejected
        dp_busy = 1'b1;
        axi_write(4'h4, 32'hDEAD_BEEF, resp);
        chk("busy_bresp", 32'(resp), 32'h2);
        chk("busy_stream_en", 32'(stream_en), 32'd1);
        chk("busy_no_we", 32'(sr_pulses), 32'd16);

        // sR write in RUN while idle restarts loading at index 0
        dp_busy = 1'b0;
        mon_sr_exp = 0;
        axi_write(4'h4, 32'hA000_0000, resp);
        chk("idle_bresp", 32'(resp), 32'h0);
        chk("idle_stream_en", 32'(stream_en), 32'd0);
        chk("idle_sr_pulses", 32'(sr_pulses), 32'd17);
        chk("idle_sr_bad", 32'(sr_bad), 32'd0);
        axi_read(4'h4, rd);
        chk("idle_sr_cnt", rd, 32'd1);
        axi_read(4'h0, rd);
        chk("idle_mat_cnt", rd, 32'd0);

        // Debug plus soft restart
        axi_write(4'hC, 32'h3, resp);
        chk("ctrl_bresp", 32'(resp), 32'h0);
        chk("ctrl_debug", 32'(debug), 32'd1);
        axi_read(4'h4, rd);
        chk("soft_sr_cnt", rd, 32'd0);
        axi_read(4'h8, rd);
        chk("soft_srs_kept", rd, 32'h5D62_0008);
        axi_read(4'hC, rd);
        chk("soft_ctrl", rd, 32'h1);

        // Async reset with a write response in flight
        mon_mat_exp = 0;
        for (int i = 0; i < 3; i++) axi_write(4'h0, 32'(i), resp);
        @(negedge clk);
        bus.s_awaddr = 4'h0; bus.s_wdata = 32'd3; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("arst_mat_we", 32'(mat_we), 32'd0);
        chk("arst_mat_addr", 32'(mat_addr), 32'd0);
        chk("arst_bvalid", 32'(bus.s_bvalid), 32'd0);
        chk("arst_debug", 32'(debug), 32'd0);
        chk("arst_srs", srs, 32'd0);
        chk("arst_stream_en", 32'(stream_en), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        axi_read(4'h0, rd);
        chk("post_rst_mat_cnt", rd, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
